// File: rtl/timer_responder.sv
// Memory-mapped timer: reloadable up-counter with overflow interrupt plus free-running SYSTICK.
// Reads are combinational (zero wait states); writes land on the next rising edge.
module timer_responder #(
   parameter logic [31:0] BASE_ADDR = 32'h4000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        rd,
   input  logic        wr,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        irqout
);

   localparam logic [2:0] OFF_TH      = 3'd0;
   localparam logic [2:0] OFF_TL      = 3'd1;
   localparam logic [2:0] OFF_TCON    = 3'd2;
   localparam logic [2:0] OFF_SYSTICK = 3'd5;

   logic [31:0] th_q, th_d;
   logic [31:0] tl_q, tl_d;
   logic [2:0]  tcon_q, tcon_d;
   logic [31:0] systick_q, systick_d;

   logic        hit;
   logic [2:0]  off;
   logic        wr_th, wr_tl, wr_tcon;
   logic        ovf;
   logic        unused_addr_bits;

   assign hit              = (addr[30:5] == BASE_ADDR[30:5]);
   assign off              = addr[4:2];
   assign unused_addr_bits = ^{addr[31], addr[1:0]};

   assign wr_th   = wr && hit && (off == OFF_TH);
   assign wr_tl   = wr && hit && (off == OFF_TL);
   assign wr_tcon = wr && hit && (off == OFF_TCON);

   // A software write to TL pre-empts the wrap, so the reload and status set are suppressed.
   assign ovf = tcon_q[0] && (tl_q == 32'hFFFF_FFFF) && !wr_tl;

   always_comb begin
      rdata = 32'd0;
      if (rd && hit) begin
         case (off)
            OFF_TH:      rdata = th_q;
            OFF_TL:      rdata = tl_q;
            OFF_TCON:    rdata = {29'd0, tcon_q};
            OFF_SYSTICK: rdata = systick_q;
            default:     rdata = 32'd0;
         endcase
      end
   end

   always_comb begin
      th_d      = wr_th ? wdata : th_q;
      systick_d = systick_q + 32'd1;

      tl_d = tl_q;
      if (wr_tl) begin
         tl_d = wdata;
      end else if (tcon_q[0]) begin
         tl_d = ovf ? th_q : tl_q + 32'd1;
      end

      // Status set is OR-ed in after a TCON write so a coincident overflow is never lost.
      tcon_d = tcon_q;
      if (wr_tcon) begin
         tcon_d    = wdata[2:0];
         tcon_d[2] = wdata[2] | (ovf & wdata[1]);
      end else if (ovf && tcon_q[1]) begin
         tcon_d[2] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         th_q      <= 32'd0;
         tl_q      <= 32'd0;
         tcon_q    <= 3'd0;
         systick_q <= 32'd0;
      end else begin
         th_q      <= th_d;
         tl_q      <= tl_d;
         tcon_q    <= tcon_d;
         systick_q <= systick_d;
      end
   end

   assign irqout = tcon_q[1] & tcon_q[2];

endmodule
